// File: rtl/clause_database_pkg.sv
// Shared sizing and the packed clause record used by the clause store and its users.
package sysdefs;

  localparam int VAR_PER_CLAUSE   = 5;
  localparam int MAX_VARS_BITS    = 8;
  localparam int MAX_CLAUSES      = 64;
  localparam int MAX_CLAUSES_BITS = $clog2(MAX_CLAUSES);

  // Count is one bit wider than the index so that "full" is representable.
  localparam logic [MAX_CLAUSES_BITS:0] CLAUSE_CAP = (MAX_CLAUSES_BITS+1)'(MAX_CLAUSES);

  typedef struct packed {
    logic [VAR_PER_CLAUSE-1:0]                    mask;
    logic [VAR_PER_CLAUSE-1:0]                    pole;
    logic [VAR_PER_CLAUSE-1:0][MAX_VARS_BITS-1:0] vars;
  } clause_t;

endpackage

// File: rtl/clause_database_mem.sv
// 1-write / 1-read clause array; the read data register only loads on an accepted read.
import sysdefs::*;

module clause_mem (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        i_we,
  input  logic [MAX_CLAUSES_BITS-1:0] i_waddr,
  input  clause_t                     i_wdata,
  input  logic                        i_re,
  input  logic [MAX_CLAUSES_BITS-1:0] i_raddr,
  output clause_t                     o_rdata
);

  clause_t r_mem [MAX_CLAUSES];
  clause_t r_rdata;

  // Storage is never cleared; the owner's count makes stale entries unreachable.
  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/clause_database.sv
// Append-only clause store: sequential push, random-index read, full and error reporting.
import sysdefs::*;

module clause_database (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    push,
  input  logic                                    read,
  input  logic [VAR_PER_CLAUSE-1:0]               mask_in,
  input  logic [VAR_PER_CLAUSE-1:0]               pole_in,
  input  logic [VAR_PER_CLAUSE*MAX_VARS_BITS-1:0] var_in,
  input  logic [MAX_CLAUSES_BITS-1:0]             index_in,
  output logic [VAR_PER_CLAUSE-1:0]               mask_out,
  output logic [VAR_PER_CLAUSE-1:0]               pole_out,
  output logic [VAR_PER_CLAUSE*MAX_VARS_BITS-1:0] var_out,
  output logic                                    full,
  output logic                                    error
);

  logic [MAX_CLAUSES_BITS:0] r_count;
  logic                      r_error;

  logic    w_full;
  logic    w_push_ok;
  logic    w_push_bad;
  logic    w_rd_ok;
  logic    w_rd_bad;
  clause_t w_wdata;
  clause_t w_rdata;

  assign w_full     = (r_count == CLAUSE_CAP);
  assign w_push_ok  = push & ~w_full;
  assign w_push_bad = push &  w_full;

  // Read legality uses the pre-push count, so a same-cycle push is not yet visible.
  assign w_rd_ok  = read & ({1'b0, index_in} < r_count);
  assign w_rd_bad = read & ~w_rd_ok;

  assign w_wdata.mask = mask_in;
  assign w_wdata.pole = pole_in;
  assign w_wdata.vars = var_in;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_error <= 1'b0;
    end else begin
      if (w_push_ok) r_count <= r_count + 1'b1;
      r_error <= w_push_bad | w_rd_bad;
    end
  end

  clause_mem u_mem (
    .clock   (clock),
    .reset   (reset),
    .i_we    (w_push_ok),
    .i_waddr (r_count[MAX_CLAUSES_BITS-1:0]),
    .i_wdata (w_wdata),
    .i_re    (w_rd_ok),
    .i_raddr (index_in),
    .o_rdata (w_rdata)
  );

  assign mask_out = w_rdata.mask;
  assign pole_out = w_rdata.pole;
  assign var_out  = w_rdata.vars;
  assign full     = w_full;
  assign error    = r_error;

endmodule

// File: tb/tb_clause_database.sv
// Directed bench for clause_database: read-vector table plus push/overflow/simultaneous sequences.
import sysdefs::*;

module tb_clause_database;

  logic                                    clock = 1'b0;
  logic                                    reset = 1'b0;
  logic                                    push = 1'b0;
  logic                                    read = 1'b0;
  logic [VAR_PER_CLAUSE-1:0]               mask_in = '0;
  logic [VAR_PER_CLAUSE-1:0]               pole_in = '0;
  logic [VAR_PER_CLAUSE*MAX_VARS_BITS-1:0] var_in = '0;
  logic [MAX_CLAUSES_BITS-1:0]             index_in = '0;
  logic [VAR_PER_CLAUSE-1:0]               mask_out;
  logic [VAR_PER_CLAUSE-1:0]               pole_out;
  logic [VAR_PER_CLAUSE*MAX_VARS_BITS-1:0] var_out;
  logic                                    full;
  logic                                    error;

  clause_database dut (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .read     (read),
    .mask_in  (mask_in),
    .pole_in  (pole_in),
    .var_in   (var_in),
    .index_in (index_in),
    .mask_out (mask_out),
    .pole_out (pole_out),
    .var_out  (var_out),
    .full     (full),
    .error    (error)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  clause_t pushed [MAX_CLAUSES+1];
  clause_t held;
  clause_t zero_c;

  typedef struct {
    logic [MAX_CLAUSES_BITS-1:0] idx;
    logic                        exp_err;
    int                          sel;   // pushed[] entry expected, -1 = data held
  } rd_vec_t;

  rd_vec_t vt [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_data(input string name, input clause_t c);
    chk({name, ".mask"}, 64'(mask_out), 64'(c.mask));
    chk({name, ".pole"}, 64'(pole_out), 64'(c.pole));
    chk({name, ".var"},  64'(var_out),  64'(c.vars));
  endtask

  function automatic clause_t rnd_clause();
    clause_t c;
    c.mask = VAR_PER_CLAUSE'($urandom);
    for (int j = 0; j < VAR_PER_CLAUSE; j++) begin
      c.pole[j] = c.mask[j] ? 1'($urandom) : 1'b0;
      c.vars[j] = c.mask[j] ? MAX_VARS_BITS'($urandom) : '0;
    end
    return c;
  endfunction

  task automatic cyc(input logic p, input logic r, input logic [MAX_CLAUSES_BITS-1:0] idx,
                     input clause_t c);
    push = p; read = r; index_in = idx;
    mask_in = c.mask; pole_in = c.pole; var_in = c.vars;
    @(posedge clock); #1;
    push = 1'b0; read = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  initial begin
    zero_c = '0;

    // Reset state
    do_reset();
    chk("rst.full", 64'(full), 64'd0);
    chk("rst.err",  64'(error), 64'd0);
    chk_data("rst", zero_c);

    // Read from an empty store
    cyc(1'b0, 1'b1, 6'd7, zero_c);
    chk("empty.err", 64'(error), 64'd1);
    chk_data("empty", zero_c);
    cyc(1'b0, 1'b0, 6'd0, zero_c);
    chk("pulse.err", 64'(error), 64'd0);

    // Fill 25 clauses
    for (int i = 0; i < 25; i++) begin
      pushed[i] = rnd_clause();
      cyc(1'b1, 1'b0, 6'd0, pushed[i]);
      if (i == 0 || i == 24) chk("fill.err", 64'(error), 64'd0);
    end
    chk("fill.full", 64'(full), 64'd0);

    // Read vectors with count = 25
    vt[0] = '{6'd24, 1'b0, 24};
    vt[1] = '{6'd23, 1'b0, 23};
    vt[2] = '{6'd30, 1'b1, -1};
    vt[3] = '{6'd25, 1'b1, -1};
    vt[4] = '{6'd0,  1'b0, 0};
    vt[5] = '{6'd63, 1'b1, -1};
    vt[6] = '{6'd12, 1'b0, 12};
    vt[7] = '{6'd26, 1'b1, -1};
    held = zero_c;
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 1'b1, vt[k].idx, zero_c);
      if (vt[k].sel >= 0) held = pushed[vt[k].sel];
      chk($sformatf("vec%0d.err", k), 64'(error), 64'(vt[k].exp_err));
      chk_data($sformatf("vec%0d", k), held);
    end

    // Simultaneous push and read at the old count
    do_reset();
    chk_data("rst2", zero_c);
    for (int i = 0; i < 3; i++) begin
      pushed[i] = rnd_clause();
      cyc(1'b1, 1'b0, 6'd0, pushed[i]);
    end
    cyc(1'b0, 1'b1, 6'd2, zero_c);
    chk("pre.err", 64'(error), 64'd0);
    chk_data("pre", pushed[2]);
    pushed[3] = rnd_clause();
    cyc(1'b1, 1'b1, 6'd3, pushed[3]);
    chk("simul.err", 64'(error), 64'd1);
    chk_data("simul", pushed[2]);
    cyc(1'b0, 1'b1, 6'd3, zero_c);
    chk("simul_next.err", 64'(error), 64'd0);
    chk_data("simul_next", pushed[3]);

    // Fill to capacity (count is 4 here)
    for (int i = 4; i < MAX_CLAUSES; i++) begin
      pushed[i] = rnd_clause();
      if (i == MAX_CLAUSES-1) chk("almost.full", 64'(full), 64'd0);
      cyc(1'b1, 1'b0, 6'd0, pushed[i]);
    end
    chk("cap.full", 64'(full), 64'd1);
    chk("cap.err",  64'(error), 64'd0);

    // Overflow push
    pushed[MAX_CLAUSES] = rnd_clause();
    pushed[MAX_CLAUSES].mask = ~pushed[MAX_CLAUSES-1].mask;
    cyc(1'b1, 1'b0, 6'd0, pushed[MAX_CLAUSES]);
    chk("ovf.err",  64'(error), 64'd1);
    chk("ovf.full", 64'(full), 64'd1);
    cyc(1'b0, 1'b1, 6'd63, zero_c);
    chk("ovf_rd.err", 64'(error), 64'd0);
    chk_data("ovf_rd63", pushed[MAX_CLAUSES-1]);
    cyc(1'b0, 1'b1, 6'd0, zero_c);
    chk_data("ovf_rd0", pushed[0]);

    // Reset empties the store
    do_reset();
    chk("rst3.full", 64'(full), 64'd0);
    cyc(1'b0, 1'b1, 6'd0, zero_c);
    chk("rst3_rd.err", 64'(error), 64'd1);
    chk_data("rst3_rd", zero_c);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clause_database.md
Name: clause_database

Overview:
- Append-only clause store for the SAT solver datapath: the loader pushes clauses sequentially; the propagation/decision logic reads any stored clause by index.
- Each clause has VAR_PER_CLAUSE literal slots. Each slot holds a valid mask bit, a polarity bit and a variable ID.
- Reports full when capacity is reached.
- Flags error on illegal accesses: read of an unwritten index, or push while full.

Parameters:
- VAR_PER_CLAUSE, 5, literal slots per clause.
- MAX_VARS_BITS, 8, width of a variable ID.
- MAX_CLAUSES, 64, clause capacity.
- MAX_CLAUSES_BITS, 6, index width; equals clog2(MAX_CLAUSES).

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- push  in  1  append {mask_in, pole_in, var_in} at the next free index.
- read  in  1  read the clause at index_in.
- mask_in  in  VAR_PER_CLAUSE  per-slot literal-valid bits.
- pole_in  in  VAR_PER_CLAUSE  per-slot polarity bits (1 = positive literal).
- var_in  in  VAR_PER_CLAUSE x MAX_VARS_BITS  per-slot variable IDs; slot j occupies bits [j*MAX_VARS_BITS +: MAX_VARS_BITS].
- index_in  in  MAX_CLAUSES_BITS  read address.
- mask_out  out  VAR_PER_CLAUSE  mask of the read clause.
- pole_out  out  VAR_PER_CLAUSE  polarity of the read clause.
- var_out  out  VAR_PER_CLAUSE x MAX_VARS_BITS  variable IDs of the read clause.
- full  out  1  count == MAX_CLAUSES.
- error  out  1  previous cycle's access was illegal.

Behaviour:
- State:
  - count: MAX_CLAUSES_BITS+1 bits, number of stored clauses.
  - Storage array: MAX_CLAUSES entries of {mask, pole, var}.
  - Registered outputs: mask_out, pole_out, var_out, error.
- Reset (reset=0, asynchronous):
  - count=0; mask_out=0, pole_out=0, var_out=0, error=0.
  - full=0 (it is derived from count).
  - Storage contents are not cleared; they are unreachable because count=0.
- full: combinational, full = (count == MAX_CLAUSES).
- Push (rising edge with push=1):
  - If count < MAX_CLAUSES: store the inputs at entry[count] exactly as given (masked-off slots are stored unmodified); count += 1.
  - If full: no write, count unchanged, error=1 next cycle.
- Read (rising edge with read=1), one-cycle latency; outputs are valid after the edge:
  - If index_in < count: mask_out/pole_out/var_out <= entry[index_in].
  - If index_in >= count, including index_in == count: error=1 and the data outputs hold their previous values.
- error:
  - Recomputed every cycle.
  - Set to 1 if either the read or the push in the cycle is illegal; otherwise 0. It is a single-cycle pulse, not sticky.
- When read=0, the data outputs hold their last value.
- Simultaneous push and read:
  - Both are performed.
  - The read is checked against and sees pre-push state. Reading index == old count is an error; the new clause is readable from the next cycle.
- No delete or overwrite. Only reset empties the database.
- An index_in value at or above MAX_CLAUSES is always an error and never aliases.

Decomposition:
- Shared package sysdefs provides VAR_PER_CLAUSE, MAX_VARS_BITS, MAX_CLAUSES, MAX_CLAUSES_BITS.
- sysdefs also provides a packed typedef clause_t {mask[VAR_PER_CLAUSE], pole[VAR_PER_CLAUSE], var[VAR_PER_CLAUSE][MAX_VARS_BITS]}.
- Optional sub-module clause_mem: a 1-write/1-read synchronous array of clause_t with registered read port.
- clause_database keeps count, full/error logic and output registers.

Test Plan:
- Reset: reset=0 for one cycle, then reset=1 -> full=0, error=0, all data outputs 0.
- Read empty: read=1, index_in=7 with count=0 -> next cycle error=1, outputs unchanged (0).
- Fill and read back:
  - Push 25 random clauses, with pole/var forced to 0 where mask=0.
  - Read index 24 -> outputs equal the 25th pushed clause, error=0.
  - Read index 23 -> outputs equal the 24th pushed clause, error=0.
- Out of range:
  - With count=25, read index_in=30 -> error=1, data held.
  - With count=25, read index_in=25 -> error=1, data held.
- Overflow:
  - Push MAX_CLAUSES=64 clauses -> full=1 after the 64th edge.
  - 65th push -> error=1, count stays 64, entry 63 unchanged on readback.
- Simultaneous push and read:
  - count=3, push=1 with read=1, index_in=3 -> error=1.
  - Next cycle read index 3 -> returns the pushed clause, error=0.
